// File: rtl/wisc_pkg.sv
// Shared types and constants for the WISC-15 memory port arbiter.
package wisc_pkg;

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE,
    BUSY_I,
    BUSY_D
  } arb_state_e;

  // Requester select
  localparam logic REQ_I = 1'b0;
  localparam logic REQ_D = 1'b1;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Pipeline-side and memory-side signals of the unified memory port.
interface mem_port_arbiter_if;
  import wisc_pkg::*;

  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic [DATA_W-1:0] i_rdata;
  logic              i_done;
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [DATA_W-1:0] d_rdata;
  logic              d_done;
  logic              if_stall;
  logic              mem_stall;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_rdy;
  logic              to_err;

  // Arbiter side
  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_rdy,
    output i_rdata, i_done, d_rdata, d_done, if_stall, mem_stall,
           mem_en, mem_we, mem_addr, mem_wdata, to_err
  );

  // Pipeline plus memory side
  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_rdy,
    input  i_rdata, i_done, d_rdata, d_done, if_stall, mem_stall,
           mem_en, mem_we, mem_addr, mem_wdata, to_err
  );

endinterface

// File: rtl/arb_watchdog.sv
// Watchdog for a memory that never raises mem_rdy: counts stalled BUSY cycles,
// pulses expire at TIMEOUT and latches a sticky error.
module arb_watchdog #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned TO_W    = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic count_en,
  output logic expire,
  output logic to_err
);

  logic [TO_W-1:0] cnt_q, cnt_d;
  logic            to_err_q;

  // Expire in the cycle whose count would reach TIMEOUT
  always_comb begin
    expire = count_en & (cnt_q == TO_W'(TIMEOUT - 1));
    cnt_d  = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (count_en) begin
      cnt_d = cnt_q + TO_W'(1);
    end
  end

  // Counter and sticky error flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      to_err_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      to_err_q <= to_err_q | expire;
    end
  end

  assign to_err = to_err_q;

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single memory port between fetch (IF) and load/store (MEM),
// data first, one access at a time, with a watchdog on the memory response.
module mem_port_arbiter
  import wisc_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned TO_W    = 8
) (
  input logic               clk,
  input logic               rst_n,
  mem_port_arbiter_if.slave bus
);

  arb_state_e        state_q, state_d;
  logic              i_elig, d_elig, grant, gnt_sel, busy, finish, expire, wd_err;
  logic              mem_en_q, mem_we_q, i_done_q, d_done_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q, i_rdata_q, d_rdata_q;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: grant from IDLE, return on response or watchdog expiry
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (d_elig) begin
          state_d = BUSY_D;
        end else if (i_elig) begin
          state_d = BUSY_I;
        end
      end
      BUSY_I, BUSY_D: begin
        if (bus.mem_rdy || expire) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Decoded controls and stalls; a requester in its done cycle is not eligible
  always_comb begin
    i_elig        = bus.i_req & ~i_done_q;
    d_elig        = bus.d_req & ~d_done_q;
    busy          = (state_q != IDLE);
    grant         = (state_q == IDLE) & (d_elig | i_elig);
    gnt_sel       = d_elig ? REQ_D : REQ_I;
    finish        = busy & (bus.mem_rdy | expire);
    bus.if_stall  = i_elig;
    bus.mem_stall = d_elig;
  end

  // Memory request registers, done pulses and read data capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      i_done_q    <= 1'b0;
      d_done_q    <= 1'b0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
    end else begin
      mem_en_q <= grant;
      i_done_q <= finish & (state_q == BUSY_I);
      d_done_q <= finish & (state_q == BUSY_D);
      if (grant) begin
        if (gnt_sel == REQ_D) begin
          mem_addr_q  <= bus.d_addr;
          mem_we_q    <= bus.d_we;
          mem_wdata_q <= bus.d_wdata;
        end else begin
          mem_addr_q  <= bus.i_addr;
          mem_we_q    <= 1'b0;
          mem_wdata_q <= '0;
        end
      end
      // An aborted access returns zero; a completed store leaves d_rdata alone
      if (finish && state_q == BUSY_I) begin
        i_rdata_q <= bus.mem_rdy ? bus.mem_rdata : '0;
      end
      if (finish && state_q == BUSY_D && !(bus.mem_rdy && mem_we_q)) begin
        d_rdata_q <= bus.mem_rdy ? bus.mem_rdata : '0;
      end
    end
  end

  arb_watchdog #(
    .TIMEOUT (TIMEOUT),
    .TO_W    (TO_W)
  ) u_watchdog (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (grant),
    .count_en (busy & ~bus.mem_rdy),
    .expire   (expire),
    .to_err   (wd_err)
  );

  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.i_done    = i_done_q;
  assign bus.d_done    = d_done_q;
  assign bus.i_rdata   = i_rdata_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.to_err    = wd_err;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: memory responder with programmable latency,
// done/rdata scoreboard keyed on the expected completion cycle.
module tb_mem_port_arbiter;
  import wisc_pkg::*;

  localparam int unsigned TIMEOUT = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  mem_port_arbiter_if bus ();

  mem_port_arbiter #(
    .TIMEOUT (TIMEOUT),
    .TO_W    (8)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    int          cyc;
    logic [15:0] rdata;
  } exp_t;

  exp_t        i_q[$];
  exp_t        d_q[$];
  int          en_log[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  int          mem_lat = 1;   // 0 = memory never responds
  bit          inject_rdy = 1'b0;
  logic [15:0] mem_model [int];

  always @(posedge clk) cyc <= cyc + 1;

  // Memory responder: mem_rdy in the mem_lat-th cycle after the grant edge
  initial begin
    bit          active;
    int          k;
    int          a;
    logic        we;
    active        = 1'b0;
    k             = 0;
    a             = 0;
    we            = 1'b0;
    bus.mem_rdy   = 1'b0;
    bus.mem_rdata = 16'h0;
    forever begin
      @(posedge clk);
      #1;
      bus.mem_rdy = 1'b0;
      if (!rst_n) begin
        active = 1'b0;
      end else if (bus.mem_en) begin
        active = 1'b1;
        k      = 1;
        a      = int'(bus.mem_addr);
        we     = bus.mem_we;
        if (we) mem_model[a] = bus.mem_wdata;
        en_log.push_back(cyc);
      end else if (active) begin
        k++;
      end
      if (active && mem_lat != 0 && k == mem_lat) begin
        bus.mem_rdy   = 1'b1;
        bus.mem_rdata = we ? 16'hFFFF : (mem_model.exists(a) ? mem_model[a] : 16'hDEAD);
        active        = 1'b0;
      end
      if (inject_rdy) begin
        bus.mem_rdy   = 1'b1;
        bus.mem_rdata = 16'h7777;
        inject_rdy    = 1'b0;
      end
    end
  end

  // Scoreboard: every done pulse must match the head of its queue
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.i_done === 1'b1) begin
        n_tests++;
        if (i_q.size() == 0) begin
          n_fail++;
          $display("FAIL i_done_unexpected: i_done=1 at cycle %0d, expected 0", cyc);
        end else begin
          e = i_q.pop_front();
          if (cyc != e.cyc || bus.i_rdata !== e.rdata) begin
            n_fail++;
            $display("FAIL i_done_result: cycle %0d rdata %h, expected cycle %0d rdata %h",
                     cyc, bus.i_rdata, e.cyc, e.rdata);
          end
        end
      end
      if (bus.d_done === 1'b1) begin
        n_tests++;
        if (d_q.size() == 0) begin
          n_fail++;
          $display("FAIL d_done_unexpected: d_done=1 at cycle %0d, expected 0", cyc);
        end else begin
          e = d_q.pop_front();
          if (cyc != e.cyc || bus.d_rdata !== e.rdata) begin
            n_fail++;
            $display("FAIL d_done_result: cycle %0d rdata %h, expected cycle %0d rdata %h",
                     cyc, bus.d_rdata, e.cyc, e.rdata);
          end
        end
      end
    end
  end

  task automatic push_i(input int dc, input logic [15:0] rd);
    exp_t e;
    e.cyc   = dc;
    e.rdata = rd;
    i_q.push_back(e);
  endtask

  task automatic push_d(input int dc, input logic [15:0] rd);
    exp_t e;
    e.cyc   = dc;
    e.rdata = rd;
    d_q.push_back(e);
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #2;
    n_tests++;
    if (bus.mem_en !== 1'b0 || bus.mem_we !== 1'b0 || bus.to_err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: en/we/err=%b%b%b, expected 000",
               bus.mem_en, bus.mem_we, bus.to_err);
    end
    n_tests++;
    if (bus.i_done !== 1'b0 || bus.d_done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_done: i/d=%b%b, expected 00", bus.i_done, bus.d_done);
    end
    n_tests++;
    if (bus.mem_addr !== 16'h0 || bus.mem_wdata !== 16'h0 ||
        bus.i_rdata !== 16'h0 || bus.d_rdata !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_data: addr %h wdata %h i_rdata %h d_rdata %h, expected all 0",
               bus.mem_addr, bus.mem_wdata, bus.i_rdata, bus.d_rdata);
    end
    n_tests++;
    if (bus.if_stall !== 1'b0 || bus.mem_stall !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_stall: if/mem=%b%b, expected 00", bus.if_stall, bus.mem_stall);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_lone_fetch();
    int c0;
    int en_hi;
    en_log.delete();
    en_hi   = 0;
    c0      = cyc;
    mem_lat = 1;
    bus.i_addr = 16'h0040;
    bus.i_req  = 1'b1;
    push_i(c0 + 2, 16'hA5C3);
    repeat (2) begin
      @(negedge clk);
      if (bus.mem_en === 1'b1) begin
        en_hi++;
        n_tests++;
        if (bus.mem_addr !== 16'h0040 || bus.mem_we !== 1'b0) begin
          n_fail++;
          $display("FAIL fetch_req: addr %h we %b, expected 0040 0", bus.mem_addr, bus.mem_we);
        end
      end
      n_tests++;
      if (bus.if_stall !== (cyc != c0 + 2)) begin
        n_fail++;
        $display("FAIL fetch_stall: cycle %0d if_stall %b, expected %b",
                 cyc, bus.if_stall, (cyc != c0 + 2));
      end
    end
    bus.i_req = 1'b0;
    @(negedge clk);
    n_tests++;
    if (en_hi != 1 || en_log.size() != 1 || i_q.size() != 0) begin
      n_fail++;
      $display("FAIL fetch_en_once: mem_en cycles %0d log %0d pending %0d, expected 1 1 0",
               en_hi, en_log.size(), i_q.size());
    end
  endtask

  task automatic test_simultaneous();
    int  c0;
    bit  prev_en;
    en_log.delete();
    prev_en    = 1'b0;
    c0         = cyc;
    mem_lat    = 2;
    bus.i_addr = 16'h0042;
    bus.i_req  = 1'b1;
    bus.d_addr = 16'h1000;
    bus.d_we   = 1'b0;
    bus.d_req  = 1'b1;
    push_d(c0 + 3, 16'h1234);
    push_i(c0 + 6, 16'h5A5A);
    repeat (6) begin
      @(negedge clk);
      n_tests++;
      if (prev_en && bus.mem_en === 1'b1) begin
        n_fail++;
        $display("FAIL sim_overlap: mem_en high two cycles at %0d, expected one", cyc);
      end
      prev_en = (bus.mem_en === 1'b1);
      if (cyc < c0 + 3) begin
        n_tests++;
        if (bus.mem_stall !== 1'b1 || bus.if_stall !== 1'b1) begin
          n_fail++;
          $display("FAIL sim_stall: cycle %0d mem/if stall %b%b, expected 11",
                   cyc, bus.mem_stall, bus.if_stall);
        end
      end
      if (cyc == c0 + 3) bus.d_req = 1'b0;
      if (cyc == c0 + 6) bus.i_req = 1'b0;
    end
    @(negedge clk);
    n_tests++;
    if (en_log.size() != 2 || i_q.size() != 0 || d_q.size() != 0) begin
      n_fail++;
      $display("FAIL sim_count: grants %0d pending i %0d d %0d, expected 2 0 0",
               en_log.size(), i_q.size(), d_q.size());
    end else begin
      n_tests++;
      if (en_log[0] != c0 + 1 || en_log[1] != c0 + 4) begin
        n_fail++;
        $display("FAIL sim_grants: grant cycles %0d %0d, expected %0d %0d",
                 en_log[0], en_log[1], c0 + 1, c0 + 4);
      end
    end
  endtask

  task automatic test_store();
    int c0;
    c0          = cyc;
    mem_lat     = 1;
    bus.d_addr  = 16'h2002;
    bus.d_wdata = 16'hBEEF;
    bus.d_we    = 1'b1;
    bus.d_req   = 1'b1;
    push_d(c0 + 2, 16'h1234);  // load data from the previous access is retained
    @(negedge clk);
    n_tests++;
    if (bus.mem_en !== 1'b1 || bus.mem_we !== 1'b1 ||
        bus.mem_addr !== 16'h2002 || bus.mem_wdata !== 16'hBEEF) begin
      n_fail++;
      $display("FAIL store_req: en %b we %b addr %h wdata %h, expected 1 1 2002 beef",
               bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata);
    end
    @(negedge clk);
    bus.d_req = 1'b0;
    bus.d_we  = 1'b0;
    @(negedge clk);
    n_tests++;
    if (d_q.size() != 0 || !mem_model.exists(16'h2002) || mem_model[16'h2002] !== 16'hBEEF) begin
      n_fail++;
      $display("FAIL store_write: pending %0d, memory word not beef", d_q.size());
    end
    // Read the stored word back
    c0        = cyc;
    bus.d_req = 1'b1;
    push_d(c0 + 2, 16'hBEEF);
    repeat (2) @(negedge clk);
    bus.d_req = 1'b0;
    @(negedge clk);
    n_tests++;
    if (d_q.size() != 0) begin
      n_fail++;
      $display("FAIL store_readback: pending %0d, expected 0", d_q.size());
    end
  endtask

  task automatic test_back_to_back();
    int c0;
    en_log.delete();
    c0         = cyc;
    mem_lat    = 1;
    mem_model[16'h0044] = 16'h0F0F;
    bus.i_addr = 16'h0040;
    bus.i_req  = 1'b1;
    push_i(c0 + 2, 16'hA5C3);
    push_i(c0 + 5, 16'h5A5A);
    push_i(c0 + 8, 16'h0F0F);
    repeat (8) begin
      @(negedge clk);
      if (cyc == c0 + 2) bus.i_addr = 16'h0042;
      if (cyc == c0 + 5) bus.i_addr = 16'h0044;
      if (cyc == c0 + 8) bus.i_req  = 1'b0;
    end
    @(negedge clk);
    n_tests++;
    if (en_log.size() != 3 || i_q.size() != 0) begin
      n_fail++;
      $display("FAIL b2b_count: grants %0d pending %0d, expected 3 0", en_log.size(), i_q.size());
    end else begin
      for (int j = 0; j < 3; j++) begin
        n_tests++;
        if (en_log[j] != c0 + 1 + 3 * j) begin
          n_fail++;
          $display("FAIL b2b_grant%0d: cycle %0d, expected %0d", j, en_log[j], c0 + 1 + 3 * j);
        end
      end
    end
  endtask

  task automatic test_timeout();
    int c0;
    // Response in the same cycle the watchdog would fire: response wins
    c0         = cyc;
    mem_lat    = 4;
    bus.i_addr = 16'h0042;
    bus.i_req  = 1'b1;
    push_i(c0 + 5, 16'h5A5A);
    repeat (5) @(negedge clk);
    bus.i_req = 1'b0;
    n_tests++;
    if (bus.to_err !== 1'b0) begin
      n_fail++;
      $display("FAIL to_coincident_err: to_err %b, expected 0", bus.to_err);
    end
    @(negedge clk);
    // Memory never answers
    c0         = cyc;
    mem_lat    = 0;
    bus.i_addr = 16'h0050;
    bus.i_req  = 1'b1;
    push_i(c0 + 5, 16'h0000);
    repeat (5) begin
      @(negedge clk);
      if (cyc == c0 + 4) begin
        n_tests++;
        if (bus.to_err !== 1'b0) begin
          n_fail++;
          $display("FAIL to_early: to_err %b at cycle %0d, expected 0", bus.to_err, cyc);
        end
      end
    end
    bus.i_req = 1'b0;
    n_tests++;
    if (bus.to_err !== 1'b1) begin
      n_fail++;
      $display("FAIL to_set: to_err %b, expected 1", bus.to_err);
    end
    @(negedge clk);
    // Later successful access leaves the error set
    c0         = cyc;
    mem_lat    = 1;
    bus.i_addr = 16'h0040;
    bus.i_req  = 1'b1;
    push_i(c0 + 2, 16'hA5C3);
    repeat (2) @(negedge clk);
    bus.i_req = 1'b0;
    @(negedge clk);
    n_tests++;
    if (bus.to_err !== 1'b1 || i_q.size() != 0) begin
      n_fail++;
      $display("FAIL to_sticky: to_err %b pending %0d, expected 1 0", bus.to_err, i_q.size());
    end
  endtask

  task automatic test_reset_mid();
    int c0;
    int en_seen;
    c0         = cyc;
    mem_lat    = 0;
    bus.d_addr = 16'h1000;
    bus.d_we   = 1'b0;
    bus.d_req  = 1'b1;
    @(negedge clk);
    n_tests++;
    if (bus.mem_en !== 1'b1) begin
      n_fail++;
      $display("FAIL rmid_busy: mem_en %b, expected 1", bus.mem_en);
    end
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if (bus.mem_en !== 1'b0 || bus.d_done !== 1'b0 || bus.to_err !== 1'b0 ||
        bus.mem_addr !== 16'h0) begin
      n_fail++;
      $display("FAIL rmid_async: en %b done %b err %b addr %h, expected 0 0 0 0000",
               bus.mem_en, bus.d_done, bus.to_err, bus.mem_addr);
    end
    @(negedge clk);
    bus.d_req  = 1'b0;
    rst_n      = 1'b1;
    inject_rdy = 1'b1;
    en_seen    = 0;
    repeat (4) begin
      @(negedge clk);
      if (bus.mem_en === 1'b1) en_seen++;
    end
    n_tests++;
    if (en_seen != 0) begin
      n_fail++;
      $display("FAIL rmid_idle: %0d spurious mem_en cycles, expected 0", en_seen);
    end
    c0        = cyc;
    mem_lat   = 1;
    bus.d_req = 1'b1;
    push_d(c0 + 2, 16'h1234);
    repeat (2) @(negedge clk);
    bus.d_req = 1'b0;
    @(negedge clk);
    n_tests++;
    if (d_q.size() != 0) begin
      n_fail++;
      $display("FAIL rmid_next: pending %0d, expected 0", d_q.size());
    end
  endtask

  initial begin
    bus.i_req   = 1'b0;
    bus.i_addr  = 16'h0;
    bus.d_req   = 1'b0;
    bus.d_we    = 1'b0;
    bus.d_addr  = 16'h0;
    bus.d_wdata = 16'h0;
    mem_model[16'h0040] = 16'hA5C3;
    mem_model[16'h0042] = 16'h5A5A;
    mem_model[16'h1000] = 16'h1234;
    test_reset();
    test_lone_fetch();
    test_simultaneous();
    test_store();
    test_back_to_back();
    test_timeout();
    test_reset_mid();
    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    n_fail++;
    $display("FAIL global_timeout: simulation still running at %0t, expected finish", $time);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1);
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares the single-ported unified instruction/data memory of the WISC-15 5-stage pipeline between the IF stage (instruction fetch) and the MEM stage (load/store). Grants one access at a time, with the data port at fixed priority, and drives a req/rdy memory handshake. Reports per-stage stall signals to the pipeline control logic alongside the hazard-detect stall. Includes a watchdog for memories that never respond.

Parameters:
ADDR_W, 16, memory address width
DATA_W, 16, memory word width
TIMEOUT, 255, cycles in BUSY without mem_rdy before abort (1..2^TO_W-1)
TO_W, 8, watchdog counter width

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
i_req  in  1  IF fetch request; held with stable i_addr until i_done
i_addr  in  ADDR_W  fetch address
i_rdata  out  DATA_W  fetched word, valid while i_done=1
i_done  out  1  one-cycle completion pulse, fetch
d_req  in  1  MEM-stage request; held with stable d_we/d_addr/d_wdata until d_done
d_we  in  1  1=store, 0=load
d_addr  in  ADDR_W  data address
d_wdata  in  DATA_W  store data
d_rdata  out  DATA_W  load data, valid while d_done=1
d_done  out  1  one-cycle completion pulse, data
if_stall  out  1  i_req & ~i_done
mem_stall  out  1  d_req & ~d_done
mem_en  out  1  one-cycle access strobe to memory
mem_we  out  1  write enable, qualified by mem_en
mem_addr  out  ADDR_W  registered address
mem_wdata  out  DATA_W  registered write data
mem_rdata  in  DATA_W  read data, valid with mem_rdy
mem_rdy  in  1  memory completion, one cycle
to_err  out  1  sticky watchdog error flag

Behaviour:
- Reset (async, rst_n=0): state IDLE. mem_en, mem_we, i_done, d_done and to_err are 0. mem_addr, mem_wdata, i_rdata, d_rdata and the watchdog counter are 0. Takes effect immediately.
- FSM states: IDLE, BUSY_I, BUSY_D.
- Eligibility: d_elig = d_req & ~d_done; i_elig = i_req & ~i_done. A requester is never re-granted during its own done cycle.
- IDLE grant:
  - d_elig -> BUSY_D; else i_elig -> BUSY_I. Data has fixed priority.
  - At the grant edge, latch address, we (0 for fetch) and wdata into the mem_* registers.
  - Set mem_en=1 for exactly the first cycle of BUSY.
  - Clear the watchdog counter.
- BUSY_x:
  - mem_rdy is sampled in every BUSY cycle, including the mem_en cycle (zero-wait memory allowed).
  - On a sampled mem_rdy: capture mem_rdata into x_rdata (load/fetch only; d_rdata is unchanged on a store), go to IDLE, assert x_done for the next cycle only.
- Latency: grant edge E0; memory with latency L (mem_rdy in the L-th cycle after E0, L>=1) gives x_done in the cycle after E_L. Minimum 3 cycles between successive grants.
- Watchdog:
  - The counter increments each BUSY cycle without mem_rdy.
  - When the count reaches TIMEOUT: go to IDLE, pulse x_done with x_rdata=0, set to_err.
  - to_err stays set until reset.
- mem_rdy in IDLE is ignored, including a stale response after reset.
- mem_rdy coincident with a timeout: mem_rdy wins; normal completion, to_err unchanged.
- Requester drops req while BUSY: the access still completes and done is still pulsed. The requester must tolerate this.
- if_stall/mem_stall are combinational from req and registered done. No combinational path from mem_rdy to any output.

Decomposition:
- Shared package wisc_pkg:
  - ADDR_W, DATA_W
  - arbiter state enum {IDLE, BUSY_I, BUSY_D}
  - requester-select constants REQ_I, REQ_D
- One sub-module, arb_watchdog: counter, TIMEOUT compare, sticky to_err. Inputs: clear on grant, count enable in BUSY & ~mem_rdy. Output: expire pulse.
- Everything else stays flat.

Test Plan:
- Lone fetch: i_req=1, i_addr=0x0040, memory L=1 returns 0xA5C3 -> mem_en high exactly one cycle with mem_addr=0x0040, mem_we=0. i_done in cycle 2 after the grant edge with i_rdata=0xA5C3. if_stall high until i_done.
- Simultaneous requests: i_req and d_req (load 0x1000) both asserted at E0, L=2 -> data granted at E0, d_done in cycle after E2. Fetch granted at E3, i_done in cycle after E5. No overlap of mem_en pulses.
- Store: d_we=1, d_addr=0x2002, d_wdata=0xBEEF -> mem_we=1 together with mem_en, mem_wdata=0xBEEF. d_done pulses once. d_rdata retains its previous value.
- Timeout: TIMEOUT=4, mem_rdy never asserted on a fetch -> i_done pulses after 4 BUSY cycles with i_rdata=0x0000. to_err=1 and stays set across later successful accesses.
- Reset mid-access: rst_n low during BUSY_D -> mem_en/d_done/to_err low immediately. A stale mem_rdy one cycle after release causes no done pulse. The next d_req is served normally.
- Back-to-back fetches, i_req held high, L=1 -> no grant during the i_done cycle. Grants 3 cycles apart. Each i_done is exactly one cycle wide.
